// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } fetch_state_t;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO holding fetched {pc, instruction} pairs for decode; flush empties it
// and takes priority over a push on the same edge.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only allowed when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory read at a time for pc, returns PCNext to
// address_gen and buffers fetched words for decode. FETCH_MISALIGN_CHECK_EN enables misalign halt.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              BUF_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] PCNext,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misalign
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   target_eff;
    logic              bad_target;
    logic              push;
    logic              pop;
    logic              buf_empty;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    slots_used;
    logic              slot_free;
    logic              req_fire;
    logic [2*XLEN-1:0] head_data;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign target_eff = redirect_target;
    assign bad_target = |redirect_target[1:0];
    assign misalign_d = redirect && bad_target && (state_q != HALT);

    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign fetch_misalign = misalign_q;
`else
    assign target_eff = redirect_target & ~XLEN'(3);
    assign bad_target = 1'b0;
`endif

    // The in-flight request occupies a slot so its response can always be pushed.
    assign slots_used = {1'b0, buf_count} + ((state_q == ISSUE) ? '0 : (CNT_W+1)'(1));
    assign slot_free  = (slots_used < (CNT_W+1)'(BUF_DEPTH));

    always_comb begin
        state_d        = state_q;
        req_pc_d       = req_pc_q;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        if (state_q == ISSUE) imem_req_valid = slot_free && !redirect && !rst;
        req_fire = imem_req_valid && imem_req_ready;

        case (state_q)
            ISSUE: begin
                if (req_fire) begin
                    state_d  = WAIT_RSP;
                    req_pc_d = pc;
                end
            end
            WAIT_RSP: begin
                // A response arriving with a redirect is consumed here; the flush discards it.
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = ISSUE;
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) state_d = ISSUE;
            end
            HALT: state_d = HALT;
            default: state_d = ISSUE;
        endcase

        if (redirect && bad_target) state_d = HALT;

        if (rst)                                              PCNext = RESET_PC;
        else if (redirect && !bad_target && state_q != HALT)  PCNext = target_eff;
        else if (req_fire)                                    PCNext = pc + XLEN'(PC_STEP);
        else                                                  PCNext = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ISSUE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2*XLEN)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ({req_pc_q, imem_rsp_data}),
        .head_data (head_data),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign imem_addr   = pc;
    assign instr_valid = !buf_empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = head_data[XLEN-1:0];
    assign instr_pc    = head_data[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a pc-register model and a simple memory model.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] PCNext;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat    = 1;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN      (32),
        .BUF_DEPTH (2),
        .RESET_PC  (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .PCNext          (PCNext),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign  (fetch_misalign)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Counts accepted requests at negedges; returns just after the edge of the n-th accept.
    task automatic wait_accepts(input int n, input bit now, input string name);
        int cnt  = 0;
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!(now && i == 0)) @(negedge clk);
            if (imem_req_valid && imem_req_ready) cnt++;
            if (cnt >= n) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: got %0d accepts, required %0d", name, cnt, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // address_gen pc register plus an instruction memory with programmable latency.
    initial begin : env
        logic [31:0] pc_nxt_s;
        logic [31:0] acc_addr;
        logic [31:0] pend_addr;
        logic        acc;
        int          pend_cnt;
        pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        pend_cnt = 0; pend_addr = 32'h0;
        forever begin
            @(negedge clk);
            pc_nxt_s = PCNext;
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_addr;
            @(posedge clk); #1;
            pc = pc_nxt_s;
            imem_rsp_valid = 1'b0;
            if (acc) begin
                pend_addr = acc_addr;
                pend_cnt  = lat;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = 32'h13 + (pend_addr << 5);
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc 0x%08h word 0x%08h, required no output", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    $display("instr pc=0x%08h word=0x%08h", instr_pc, instr);
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr_word", instr, e.word);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got no finish, required finish before 50000");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
        imem_req_ready = 1'b0; instr_ready = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pcnext", PCNext, 32'h0);
        chk("rst_req_valid", imem_req_valid, 32'h0);
        chk("rst_instr_valid", instr_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misalign", fetch_misalign, 32'h0);
`endif

        // Release and stream three words with latency 1
        @(posedge clk); #1;
        rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        exp_q.push_back('{pc: 32'h0, word: 32'h13});
        exp_q.push_back('{pc: 32'h4, word: 32'h93});
        exp_q.push_back('{pc: 32'h8, word: 32'h113});
        @(negedge clk);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_req_valid", imem_req_valid, 32'h1);
        chk("first_pcnext", PCNext, 32'h4);
        wait_accepts(3, 1'b1, "stream_accepts");
        imem_req_ready = 1'b0;
        wait_drain("stream_drain");
        chk("stall_pcnext_hold", PCNext, 32'hC);
        chk("stall_addr", imem_addr, 32'hC);

        // Decode stalled: buffer fills after two pushes and fetch stops
        @(posedge clk); #1;
        instr_ready = 1'b0; imem_req_ready = 1'b1;
        exp_q.push_back('{pc: 32'hC,  word: 32'h193});
        exp_q.push_back('{pc: 32'h10, word: 32'h213});
        repeat (6) @(negedge clk);
        chk("full_req_valid", imem_req_valid, 32'h0);
        chk("full_pcnext_hold", PCNext, 32'h14);
        chk("full_instr_valid", instr_valid, 32'h1);
        chk("full_head_pc", instr_pc, 32'hC);
        exp_q.push_back('{pc: 32'h14, word: 32'h293});
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_accepts(1, 1'b0, "resume_accept");
        imem_req_ready = 1'b0;
        wait_drain("resume_drain");

        // Redirect while a latency-2 response is outstanding
        lat = 2;
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        wait_accepts(1, 1'b0, "redir_accept");
        redirect = 1'b1; redirect_target = 32'h100; imem_req_ready = 1'b0;
        @(negedge clk);
        chk("redir_pcnext", PCNext, 32'h100);
        chk("redir_req_valid", imem_req_valid, 32'h0);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("drain_instr_valid", instr_valid, 32'h0);
        chk("drain_pcnext", PCNext, 32'h100);
        chk("drain_req_valid", imem_req_valid, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_drain_req_valid", imem_req_valid, 32'h1);
        chk("after_drain_addr", imem_addr, 32'h100);
        chk("after_drain_empty", instr_valid, 32'h0);
        lat = 1;
        exp_q.push_back('{pc: 32'h100, word: 32'h2013});
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        wait_accepts(1, 1'b0, "redir_fetch");
        imem_req_ready = 1'b0;
        wait_drain("redir_fetch_drain");

        // PC wrap at the top of the address space
        @(posedge clk); #1;
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_redirect_pcnext", PCNext, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        redirect = 1'b0; imem_req_ready = 1'b1;
        exp_q.push_back('{pc: 32'hFFFF_FFFC, word: 32'hFFFF_FF93});
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pcnext", PCNext, 32'h0);
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        wait_drain("wrap_drain");

        // Reset during an outstanding request drops the late response
        lat = 2;
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        wait_accepts(1, 1'b0, "midrst_accept");
        rst = 1'b1; imem_req_ready = 1'b0;
        @(negedge clk);
        chk("midrst_pcnext", PCNext, 32'h0);
        chk("midrst_req_valid", imem_req_valid, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_dropped", instr_valid, 32'h0);
        lat = 1;

        // Misaligned redirect target
        @(posedge clk); #1;
        redirect = 1'b1; redirect_target = 32'h102;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign_pcnext_hold", PCNext, 32'h0);
        chk("misalign_pre", fetch_misalign, 32'h0);
        @(posedge clk); #1;
        redirect = 1'b0; imem_req_ready = 1'b1;
        @(negedge clk);
        chk("misalign_pulse", fetch_misalign, 32'h1);
        chk("halt_req_valid", imem_req_valid, 32'h0);
        chk("halt_pcnext", PCNext, 32'h0);
        @(negedge clk);
        chk("misalign_clear", fetch_misalign, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_no_req", imem_req_valid, 32'h0);
        end
        imem_req_ready = 1'b0;
`else
        chk("align_forced_pcnext", PCNext, 32'h100);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("align_addr", imem_addr, 32'h100);
        chk("align_req_valid", imem_req_valid, 32'h1);
`endif

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
